mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Clocked arbiter/sequencer that shares the single read/write port (port 2) of the physical
//  memory between the instruction-cache refill path (read-only) and the data-cache path (read/write).
//  It owns the port's enable/address/data/direction signals and waits for the memory's ready.
//  It returns the line to the winning requester with a one-cycle ack pulse.
//  Sits between the two cache miss handlers and the memory module.
// PARAMETERS
//  LINE_WIDTH  `LINE_WIDTH (128)        line width in bits; same as the memory line
//  ADDR_SIZE   `PHYS_ADDR_SIZE (20)     physical byte address width
//  MAX_WAIT    64                       cycles in ISSUE before the timeout error; >=2
//  CNT_W       $clog2(MAX_WAIT+1)       wait-counter width (localparam)
// PORTS
//  clk           in   1           rising-edge clock
//  reset         in   1           asynchronous, active-low reset
//  ic_req        in   1           icache read request; held with ic_addr until ic_ack
//  ic_addr       in   ADDR_SIZE   icache physical byte address
//  ic_ack        out  1           one-cycle pulse: ic_rdata valid
//  ic_rdata      out  LINE_WIDTH  line read for icache; held until the next icache grant
//  dc_req        in   1           dcache request; held with dc_addr/dc_wdata/dc_we until dc_ack
//  dc_we         in   1           1 = write (`WRITE), 0 = read
//  dc_addr       in   ADDR_SIZE   dcache physical byte address
//  dc_wdata      in   LINE_WIDTH  write line
//  dc_ack        out  1           one-cycle pulse: read data valid or write done
//  dc_rdata      out  LINE_WIDTH  read line, held; for a write it equals the written line
//  mem_enable    out  1           to memory p2_enable
//  mem_write     out  1           to memory p2_write_or_read (`WRITE when 1)
//  mem_addr      out  ADDR_SIZE   to memory p2_address
//  mem_wdata     out  LINE_WIDTH  to memory p2_in_data
//  mem_rdata     in   LINE_WIDTH  from memory p2_out_data
//  mem_ready     in   1           from memory p2_ready; sampled on clk
//  timeout_err   out  1           sticky; set when a transaction exceeds MAX_WAIT; cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async):
//  - State IDLE; all outputs 0, including rdata and timeout_err.
//  - last_grant = DC, so the icache wins the first tie.
//  - Reset mid-transaction drops mem_enable immediately; no ack is issued.
//  FSM, registered outputs:
//  - IDLE: if any req is high, the round-robin picks the winner.
//    - Both requesting: the winner is the requester not in last_grant; a single requester wins outright.
//    - On the edge: latch addr/wdata/we into the mem_* registers (icache: we=0), set mem_enable=1,
//      update last_grant, clear wait_cnt, go to ISSUE.
//  - ISSUE: mem_* held stable; wait_cnt increments each cycle.
//    - mem_ready=1: capture mem_rdata into the winner's rdata, pulse the winner's ack next cycle,
//      set mem_enable=0, go to RESP.
//    - wait_cnt==MAX_WAIT-1 without ready: set timeout_err, ack the winner with rdata=0,
//      set mem_enable=0, go to RESP.
//  - RESP: the ack is high for exactly this cycle; requests are ignored; go to IDLE.
//  Timing:
//  - Minimum latency: req sampled at edge N -> enable high after N -> ready sampled at N+1
//    -> ack high during cycle N+2.
//  - Throughput: at most one transaction per 3 cycles.
//  - Simultaneous requests are never both acked in the same cycle; the loser stays pending and wins next.
//  - A requester must drop req in its ack cycle; req still high when the FSM is back in IDLE is a new request.
//  - mem_ready high while in IDLE or RESP is ignored.
//  - Address out of range: passed through unchecked; the memory reports it.
// STRUCTURE
//  - `memory/preprocessor_directives.v`: gains the `ARB_IDLE/`ARB_ISSUE/`ARB_RESP encodings
//    (2 bits) and the requester IDs `REQ_IC=0/`REQ_DC=1. It keeps `LINE_WIDTH, `PHYS_ADDR_SIZE and `WRITE.
//  - Sub-module rr_arbiter2: 2-input round-robin grant logic with a last_grant register updated
//    on a strobe. It is reusable for port 1 sharing later.
//  - All else is inline: FSM, request latch, wait counter, per-requester rdata registers.
// TESTING
//  1. Reset low with ic_req=1 -> all outputs 0; release reset -> icache granted first edge,
//     mem_enable=1, mem_addr=ic_addr.
//  2. Single icache read addr 0x00040, memory ready after 1 cycle, line 0xA5..A5 -> ic_ack
//     one cycle at N+2, ic_rdata=0xA5..A5, dc_ack never.
//  3. dcache write 0x00080 data 0x1234.. then dcache read 0x00080 -> mem_write=1 then 0,
//     dc_rdata=0x1234.., two dc_ack pulses.
//  4. ic_req and dc_req asserted same edge, 3 times in a row -> grants IC,DC,IC,DC,...;
//     no cycle with both acks; each ack 3 cycles apart.
//  5. MAX_WAIT=4, mem_ready held 0 -> timeout_err=1 after 4 ISSUE cycles, dc_ack with dc_rdata=0,
//     next request still served.
//  6. Reset asserted during ISSUE -> mem_enable low asynchronously, no ack; timeout_err cleared.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port-2 arbiter: line/address sizes, FSM encodings
// and requester IDs.
package mem_port_arbiter_pkg;

  localparam int DEF_LINE_WIDTH = 128;
  localparam int PHYS_ADDR_SIZE = 20;

  localparam logic WRITE = 1'b1;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin grant logic. The last_grant register only advances on
// i_update, so the caller decides when a grant is actually consumed.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  logic r_last_grant;

  // A tie goes to whoever did not win last time.
  always_comb begin
    o_grant_id = REQ_IC;
    if (&i_req)
      o_grant_id = ~r_last_grant;
    else if (i_req[REQ_DC])
      o_grant_id = REQ_DC;
    o_grant = '0;
    if (|i_req)
      o_grant = (o_grant_id == REQ_DC) ? 2'b10 : 2'b01;
  end

  // Starting at DC means the icache wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_grant <= REQ_DC;
    else if (i_update)
      r_last_grant <= o_grant_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares memory port 2 between the icache refill path and the dcache path:
// IDLE -> ISSUE (wait for ready or time out) -> RESP (one-cycle ack) -> IDLE.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int ADDR_SIZE  = PHYS_ADDR_SIZE,
  parameter int MAX_WAIT   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_SIZE-1:0]  ic_addr,
  output logic                  ic_ack,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_SIZE-1:0]  dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_ack,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [1:0]            r_state;
  logic                  r_owner;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [1:0]            w_grant;
  logic                  w_grant_id;
  logic                  w_start;
  logic                  w_done;
  logic [LINE_WIDTH-1:0] w_resp_line;

  assign w_start = (r_state == ARB_IDLE) && (|w_grant);
  assign w_done  = mem_ready || (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

  // A write returns the line it wrote; a timeout returns zero.
  assign w_resp_line = !mem_ready ? '0 : (mem_write ? mem_wdata : mem_rdata);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (reset),
    .i_req      ({dc_req, ic_req}),
    .i_update   (w_start),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  // NOTE: every register here, including the rdata lines, is reset so that an
  // aborted transaction leaves nothing behind and no ack can follow reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= REQ_IC;
      r_wait_cnt  <= '0;
      mem_enable  <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge state regardless of statement order.
      case (r_state)
        ARB_IDLE: begin
          if (w_start) begin
            r_owner    <= w_grant_id;
            r_wait_cnt <= '0;
            mem_enable <= 1'b1;
            r_state    <= ARB_ISSUE;
            if (w_grant_id == REQ_DC) begin
              mem_addr  <= dc_addr;
              mem_wdata <= dc_wdata;
              mem_write <= dc_we;
            end else begin
              mem_addr  <= ic_addr;
              mem_wdata <= '0;
              mem_write <= ~WRITE;
            end
          end
        end
        ARB_ISSUE: begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          if (w_done) begin
            mem_enable <= 1'b0;
            r_state    <= ARB_RESP;
            if (!mem_ready)
              timeout_err <= 1'b1;
            if (r_owner == REQ_DC) begin
              dc_ack   <= 1'b1;
              dc_rdata <= w_resp_line;
            end else begin
              ic_ack   <= 1'b1;
              ic_rdata <= w_resp_line;
            end
          end
        end
        ARB_RESP: begin
          ic_ack  <= 1'b0;
          dc_ack  <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory on port 2.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LW = 128;
  localparam int AW = 20;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          ic_ack, dc_ack;
  logic [LW-1:0] ic_rdata, dc_rdata;
  logic          mem_enable, mem_write, mem_ready, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WIDTH(LW), .ADDR_SIZE(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic          who;
    logic [LW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  logic [LW-1:0] store [int];
  int mem_lat  = 0;
  bit mem_hang = 1'b0;
  bit exp_last = REQ_DC;

  // Memory model: ready mem_lat cycles after enable; writes echo inverted data on rdata.
  initial begin
    int cnt;
    bit served;
    cnt = 0;
    served = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_enable) begin
        mem_ready = 1'b0;
        cnt = 0;
        served = 1'b0;
      end else if (!served && !mem_hang) begin
        if (cnt >= mem_lat) begin
          if (mem_write) begin
            store[int'(mem_addr)] = mem_wdata;
            mem_rdata = ~mem_wdata;
          end else begin
            mem_rdata = store.exists(int'(mem_addr)) ? store[int'(mem_addr)] : '0;
          end
          mem_ready = 1'b1;
          served = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Response monitor: every ack must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ic_ack || dc_ack) begin
        check("one_ack_at_a_time", LW'(ic_ack & dc_ack), '0);
        check("ack_expected", LW'(sb_q.size() != 0), LW'(1));
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("ack_who", LW'(dc_ack), LW'(e.who));
          check("ack_data", e.who ? dc_rdata : ic_rdata, e.data);
        end
      end
    end
  end

  task automatic xact(input bit who, input logic [AW-1:0] addr, input bit we,
                      input logic [LW-1:0] wd, input logic [LW-1:0] exp_data,
                      input int exp_lat, input string tag);
    int n;
    sb_q.push_back('{who: who, data: exp_data});
    exp_last = who;
    if (who) begin
      dc_req = 1'b1; dc_addr = addr; dc_we = we; dc_wdata = wd;
    end else begin
      ic_req = 1'b1; ic_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_enable"}, LW'(mem_enable), LW'(1));
        check({tag, "_addr"}, LW'(mem_addr), LW'(addr));
        check({tag, "_write"}, LW'(mem_write), LW'(we));
        if (we) check({tag, "_wdata"}, mem_wdata, wd);
      end
    end while (!(who ? dc_ack : ic_ack) && n < 200);
    check({tag, "_latency"}, LW'(n), LW'(exp_lat));
    if (who) dc_req = 1'b0; else ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic both(input logic [AW-1:0] ia, input logic [AW-1:0] da, input string tag);
    int n, ic_c, dc_c;
    bit first, ic_done, dc_done;
    first = ~exp_last;
    if (first == REQ_IC) begin
      sb_q.push_back('{who: REQ_IC, data: store[int'(ia)]});
      sb_q.push_back('{who: REQ_DC, data: store[int'(da)]});
    end else begin
      sb_q.push_back('{who: REQ_DC, data: store[int'(da)]});
      sb_q.push_back('{who: REQ_IC, data: store[int'(ia)]});
    end
    exp_last = ~first;
    ic_req = 1'b1; ic_addr = ia;
    dc_req = 1'b1; dc_addr = da; dc_we = 1'b0; dc_wdata = '0;
    n = 0; ic_c = 0; dc_c = 0; ic_done = 1'b0; dc_done = 1'b0;
    while (!(ic_done && dc_done) && n < 200) begin
      @(negedge clk);
      n++;
      if (ic_ack && !ic_done) begin ic_done = 1'b1; ic_req = 1'b0; ic_c = n; end
      if (dc_ack && !dc_done) begin dc_done = 1'b1; dc_req = 1'b0; dc_c = n; end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    check({tag, "_both_served"}, LW'(ic_done && dc_done), LW'(1));
    check({tag, "_order"}, LW'(ic_c < dc_c), LW'(first == REQ_IC));
    check({tag, "_gap"}, LW'((ic_c > dc_c) ? ic_c - dc_c : dc_c - ic_c), LW'(3));
    @(negedge clk);
  endtask

  initial begin
    logic [LW-1:0] d_a5, d_12, d_x;
    d_a5 = {16{8'hA5}};
    d_12 = {8{16'h1234}};
    d_x  = {4{32'hCAFE_0101}};
    store[32'h00010] = {8{16'h0F0F}};
    store[32'h00040] = d_a5;
    store[32'h00300] = {4{32'h1111_2222}};
    store[32'h00304] = {4{32'h3333_4444}};
    store[32'h00308] = {4{32'h5555_6666}};
    store[32'h0030C] = {4{32'h7777_8888}};
    ic_req = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    rst_n = 1'b0;

    // Reset with a pending icache request: everything quiet.
    ic_req = 1'b1; ic_addr = 20'h00010;
    repeat (3) @(negedge clk);
    check("rst_enable", LW'(mem_enable), '0);
    check("rst_write", LW'(mem_write), '0);
    check("rst_addr", LW'(mem_addr), '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_acks", LW'({ic_ack, dc_ack}), '0);
    check("rst_ic_rdata", ic_rdata, '0);
    check("rst_dc_rdata", dc_rdata, '0);
    check("rst_timeout", LW'(timeout_err), '0);
    rst_n = 1'b1;
    xact(REQ_IC, 20'h00010, 1'b0, '0, store[32'h00010], 2, "post_rst");

    // Single icache read at minimum latency.
    xact(REQ_IC, 20'h00040, 1'b0, '0, d_a5, 2, "ic_read");

    // dcache write then read-back; the write waits two extra cycles.
    mem_lat = 2;
    xact(REQ_DC, 20'h00080, 1'b1, d_12, d_12, 4, "dc_write");
    mem_lat = 0;
    xact(REQ_DC, 20'h00080, 1'b0, '0, d_12, 2, "dc_read");

    // Simultaneous requests alternate.
    both(20'h00300, 20'h00304, "rr0");
    both(20'h00308, 20'h0030C, "rr1");
    both(20'h00040, 20'h00080, "rr2");

    // Timeout, then normal service continues with the error sticky.
    check("pre_timeout", LW'(timeout_err), '0);
    mem_hang = 1'b1;
    xact(REQ_DC, 20'h00100, 1'b0, '0, '0, MW + 1, "timeout");
    check("timeout_set", LW'(timeout_err), LW'(1));
    check("timeout_rdata", dc_rdata, '0);
    mem_hang = 1'b0;
    xact(REQ_IC, 20'h00300, 1'b0, '0, store[32'h00300], 2, "after_tmo");
    check("timeout_sticky", LW'(timeout_err), LW'(1));

    // Reset during ISSUE: enable drops at once, no ack follows.
    mem_hang = 1'b1;
    dc_req = 1'b1; dc_addr = 20'h00200; dc_we = 1'b1; dc_wdata = d_x;
    repeat (2) @(negedge clk);
    check("mid_enable", LW'(mem_enable), LW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_enable", LW'(mem_enable), '0);
    check("async_timeout", LW'(timeout_err), '0);
    check("async_ic_rdata", ic_rdata, '0);
    check("async_acks", LW'({ic_ack, dc_ack}), '0);
    dc_req = 1'b0;
    mem_hang = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = REQ_DC;
    repeat (8) @(negedge clk);
    xact(REQ_IC, 20'h00040, 1'b0, '0, d_a5, 2, "after_rst");

    repeat (4) @(negedge clk);
    check("sb_drained", LW'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
